mips_byte_loader: RTL
=====================

# mips_byte_loader

Byte-serial instruction/data word assembler between the TinyTapeout pin interface and the `tt_um_ericsmi_mips` core. It accepts 8-bit bytes from the dedicated inputs, packs four of them little-endian into a 32-bit word, and presents the word to the core on a valid/ready handshake. It also provides a resync input that discards a partial word, and a wrapping count of delivered words for debug readout on `uo_out`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: idle cycles allowed between bytes of a partial word (used only with the timeout feature).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `byte_in`  in  8  byte from `ui_in`, already synchronized.
- `byte_valid`  in  1  byte strobe; a byte transfers on a cycle with `byte_valid && byte_ready`.
- `byte_ready`  out  1  loader can accept a byte.
- `resync`  in  1  discards any partial word; takes priority over `byte_valid`.
- `word_out`  out  32  assembled word; `{b3,b2,b1,b0}`, where b0 is the first byte received.
- `word_valid`  out  1  `word_out` holds a complete word.
- `word_ready`  in  1  core accepts the word; it transfers on a cycle with `word_valid && word_ready`.
- `word_count`  out  8  number of words delivered, modulo 256.
- `err_timeout`  out  1  sticky flag, set when a partial word was dropped by timeout.

## Operation
- States: IDLE (no bytes held), FILL (1–3 bytes held), HOLD (complete word held).
- A 2-bit byte index `idx` tracks position in the word. A byte accepted at `idx=k` is written to `word_out[8k+7:8k]`.
- IDLE: accepting a byte writes lane 0, sets `idx=1`, and moves to FILL.
- FILL: accepting a byte writes lane `idx`. If `idx=3`, move to HOLD and set `idx=0`; otherwise increment `idx`.
- HOLD: `word_valid=1` and `byte_ready=0`. On `word_ready`, go to IDLE, clear `word_valid`, and increment `word_count` (wraps 255→0).
- `byte_ready = (state != HOLD) && !resync`.
- `resync` in IDLE/FILL: go to IDLE, set `idx=0`, and discard any simultaneous byte.
- `resync` in HOLD: no effect. A completed word is never dropped.
- Lanes not yet written in the current word keep stale data. Only `word_valid` qualifies `word_out`.
- `word_out` is stable for the whole time `word_valid` is high.

## Timing
- Reset values: `byte_ready=1`, `word_valid=0`, `word_out=0`, `word_count=0`, `err_timeout=0`, state IDLE, `idx=0`. Reset overrides every other input in the same cycle.
- Latency: `word_valid` rises on the cycle after the 4th byte is accepted.
- Minimum word period is 5 cycles: 4 byte cycles plus 1 HOLD cycle when `word_ready` is already high.
- `byte_ready` returns high on the cycle after the HOLD handshake. A byte offered on the handshake cycle itself is not accepted.
- `word_count` updates on the cycle after the handshake.
- Reset asserted mid-word or in HOLD discards all held data with no handshake and no `word_count` change.
- `byte_valid` may be held high continuously. One byte is taken per cycle while `byte_ready=1`.

## Configuration
- Macro: `MIPS_LOADER_TIMEOUT_EN`.
- Defined:
  - An idle counter runs in FILL only. It clears on every accepted byte and on entry to FILL.
  - When it reaches `TIMEOUT_CYCLES` with no byte, the next cycle goes to IDLE with `idx=0` and sets `err_timeout=1`.
  - `err_timeout` stays set until `rst`.
  - A byte arriving on the cycle the count reaches `TIMEOUT_CYCLES` is accepted, and the timeout is cancelled.
  - The counter does not run in IDLE or HOLD.
- Undefined: no counter is built, `err_timeout` is tied to 0, `TIMEOUT_CYCLES` is ignored, and a partial word is held indefinitely.

## Test plan
- After reset, feed 0x78, 0x56, 0x34, 0x12 on 4 consecutive cycles with `word_ready=1` -> `word_valid` high on cycle 5 with `word_out=0x12345678`; `word_count=1` on cycle 6.
- Complete a word with `word_ready=0` for 10 cycles while `byte_valid` stays high -> `byte_ready=0` and `word_out` stable throughout; after `word_ready`, the next byte is accepted one cycle later into lane 0.
- Feed 0xAA, 0xBB, then pulse `resync` with `byte_valid=1`, then feed 0x01, 0x02, 0x03, 0x04 -> `word_out=0x04030201`; 0xAA and 0xBB never appear in a delivered word.
- Deliver 256 words (data `i` replicated in each byte) -> `word_count` reads 0xFF after word 255 and wraps to 0x00 after word 256; every `word_out` is correct.
- Assert `rst` with 2 bytes held, then with a word in HOLD -> `word_valid=0`, `word_count` unchanged at 0, and the next 4 bytes form a clean word.
- With `MIPS_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`: feed 1 byte, then idle 9 cycles -> `err_timeout=1` and state IDLE; repeat with a byte arriving at idle count 8 -> no timeout, and the word completes normally.

Source files
------------

// File: rtl/mips_byte_loader.sv
// mips_byte_loader
// Packs four serial bytes (first byte in the low lane) into a 32-bit word and
// hands it to the MIPS core over a valid/ready handshake. A resync input drops a
// partial word. A wrapping 8-bit counter records delivered words for debug.
// Optional feature: define MIPS_LOADER_TIMEOUT_EN to drop a partial word that
// sits idle for more than TIMEOUT_CYCLES cycles, and to set err_timeout.
module mips_byte_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        resync,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  word_count,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no bytes held
        S_FILL = 2'd1,   // one to three bytes held
        S_HOLD = 2'd2    // complete word waiting for the core
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic [7:0]  count_q;

    logic        byte_accept;
    logic        word_accept;
    logic        timeout_fire;

    assign byte_accept = byte_valid && byte_ready;
    assign word_accept = word_valid && word_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: resync beats a byte, and HOLD ignores resync.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (byte_accept) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (resync) begin
                    state_d = S_IDLE;
                end else if (byte_accept && (idx_q == 2'd3)) begin
                    state_d = S_HOLD;
                end else if (timeout_fire) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
                if (word_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        byte_ready = (state_q != S_HOLD) && !resync;
        word_valid = (state_q == S_HOLD);
    end

    // Byte index: advances per accepted byte and wraps 3 -> 0 on word completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 2'd0;
        end else if (resync && (state_q != S_HOLD)) begin
            idx_q <= 2'd0;
        end else if (byte_accept) begin
            idx_q <= idx_q + 2'd1;
        end else if (timeout_fire) begin
            idx_q <= 2'd0;
        end
    end

    // Word register: each accepted byte lands in the lane selected by idx.
    // Lanes not yet rewritten keep stale data; only word_valid qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= 32'd0;
        end else if (byte_accept) begin
            word_q[{idx_q, 3'b000} +: 8] <= byte_in;
        end
    end

    // Delivered-word counter, wraps modulo 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else if (word_accept) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign word_out   = word_q;
    assign word_count = count_q;

`ifdef MIPS_LOADER_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_q, idle_d;
    logic             err_q;

    // A byte on the cycle the limit is reached wins over the timeout.
    assign timeout_fire = (state_q == S_FILL) && !resync && !byte_accept &&
                          (idle_q == CNT_W'(TIMEOUT_CYCLES));

    // Idle counter runs only while a partial word is held.
    always_comb begin
        idle_d = '0;
        if ((state_q == S_FILL) && !byte_accept && !resync && !timeout_fire) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Idle counter register and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
            err_q  <= 1'b0;
        end else begin
            idle_q <= idle_d;
            if (timeout_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    logic unused_timeout_cfg;

    assign timeout_fire       = 1'b0;
    assign err_timeout        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule
